// File: rtl/io_mmio_defs.sv
// Shared IO MMIO definitions: base nibble, register offsets, status bits, opcodes,
// and the per-cycle access decode used by the controller.
package io_mmio_defs;

  localparam logic [3:0] IO_BASE_DEF = 4'b1000;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

  localparam int ST_TX_NFULL = 0;
  localparam int ST_RX_HELD  = 1;
  localparam int ST_TX_OVF   = 2;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_OPIMM  = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  typedef struct packed {
    logic ld_status;
    logic ld_rx;
    logic ld_cyc;
    logic ld_ins;
    logic st_tx;
    logic st_clr;
  } io_dec_t;

  // Only the top nibble qualifies IO space; offsets come from the low byte.
  function automatic io_dec_t io_decode(input logic [31:0] addr, input logic [3:0] base,
                                        input logic recv, input logic [3:0] trans);
    io_dec_t d;
    logic    sel;
    sel         = (addr[31:28] == base);
    d.ld_status = recv & sel & (addr[7:0] == OFF_STATUS);
    d.ld_rx     = recv & sel & (addr[7:0] == OFF_RXDATA);
    d.ld_cyc    = recv & sel & (addr[7:0] == OFF_CYCLE);
    d.ld_ins    = recv & sel & (addr[7:0] == OFF_INSTR);
    d.st_tx     = trans[0] & sel & (addr[7:0] == OFF_TXDATA);
    d.st_clr    = (|trans) & sel & (addr[7:0] == OFF_CLEAR);
    return d;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; pushes are dropped when full,
// head is presented with valid/ready handshake.
module io_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       pop_valid,
  output logic [7:0] pop_data,
  input  logic       pop_ready
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_valid = (count != '0);
  assign pop_data  = mem[rd_ptr];
  assign push      = push_valid & ~full;
  assign pop       = pop_valid & pop_ready;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped IO controller: UART TX FIFO, single-entry RX holding register,
// cycle/instruction counters and a registered load-data port.
module io_mmio_ctrl
  import io_mmio_defs::*;
#(
  parameter int         TX_DEPTH = 8,
  parameter logic [3:0] IO_BASE  = IO_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [3:0]  io_trans,
  input  logic        io_recv,
  input  logic [31:0] wdata,
  input  logic        instr_retire,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  io_dec_t     dec;
  logic        tx_full;
  logic        tx_ovf;
  logic        rx_held;
  logic [7:0]  rx_byte;
  logic [31:0] cyc_cnt, ins_cnt;
  logic [31:0] status;
  logic [31:0] rd_nxt;
  logic        unused_bits;

  assign unused_bits = ^{addr[27:8], wdata[31:8]};
  assign dec         = io_decode(addr, IO_BASE, io_recv, io_trans);

  io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (dec.st_tx),
    .push_data  (wdata[7:0]),
    .full       (tx_full),
    .pop_valid  (uart_tx_valid),
    .pop_data   (uart_tx_data),
    .pop_ready  (uart_tx_ready)
  );

  assign uart_rx_ready = ~rx_held;

  always_comb begin
    status              = '0;
    status[ST_TX_NFULL] = ~tx_full;
    status[ST_RX_HELD]  = rx_held;
    status[ST_TX_OVF]   = tx_ovf;
  end

  always_comb begin
    rd_nxt = '0;
    if (dec.ld_status)          rd_nxt = status;
    if (dec.ld_rx && rx_held)   rd_nxt = {24'b0, rx_byte};
    if (dec.ld_cyc)             rd_nxt = cyc_cnt;
    if (dec.ld_ins)             rd_nxt = ins_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (io_recv) rdata <= rd_nxt;
  end

  // A drop in the same cycle as a status read keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_ovf <= 1'b0;
    else if (dec.st_tx && tx_full) tx_ovf <= 1'b1;
    else if (dec.ld_status) tx_ovf <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_held <= 1'b0;
      rx_byte <= '0;
    end else if (dec.ld_rx && rx_held) begin
      rx_held <= 1'b0;
    end else if (uart_rx_valid && !rx_held) begin
      rx_held <= 1'b1;
      rx_byte <= uart_rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else if (dec.st_clr) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      ins_cnt <= ins_cnt + {31'b0, instr_retire};
    end
  end

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl: register-map vector table, directed
// corner sequences and randomized traffic against a queue-based reference model.
module tb_io_mmio_ctrl;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  io_trans = '0;
  logic        io_recv = 1'b0;
  logic [31:0] wdata = '0;
  logic        instr_retire = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;

  io_mmio_ctrl #(.TX_DEPTH(DEPTH), .IO_BASE(4'b1000)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .io_trans(io_trans), .io_recv(io_recv),
    .wdata(wdata), .instr_retire(instr_retire), .rdata(rdata),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  bit          m_ovf, m_held;
  logic [7:0]  m_rxb;
  logic [31:0] m_cyc, m_ins, m_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_held = 0; m_rxb = '0;
    m_cyc = '0; m_ins = '0; m_rdata = '0;
  endtask

  task automatic idle_in();
    io_recv = 0; io_trans = '0; instr_retire = 0; uart_rx_valid = 0;
  endtask

  // One clock: model consumes the pre-edge inputs, then DUT outputs are compared after the edge.
  task automatic tick();
    bit         sel, full, ldst, ldrx, sttx, clr, pop;
    logic [7:0] off, dummy;
    if (!rst_n) begin
      @(posedge clk); #1;
      return;
    end
    sel  = (addr[31:28] == 4'h8);
    off  = addr[7:0];
    full = (m_q.size() == DEPTH);
    if (io_recv) begin
      m_rdata = '0;
      if (sel) begin
        case (off)
          8'h00:   m_rdata = {29'b0, m_ovf, m_held, !full};
          8'h04:   m_rdata = m_held ? {24'b0, m_rxb} : 32'h0;
          8'h10:   m_rdata = m_cyc;
          8'h14:   m_rdata = m_ins;
          default: m_rdata = '0;
        endcase
      end
    end
    ldst = io_recv && sel && off == 8'h00;
    ldrx = io_recv && sel && off == 8'h04;
    sttx = sel && off == 8'h08 && io_trans[0];
    clr  = sel && off == 8'h18 && io_trans != 0;
    pop  = (m_q.size() != 0) && uart_tx_ready;
    if (sttx && full) m_ovf = 1;
    else if (ldst) m_ovf = 0;
    if (pop) dummy = m_q.pop_front();
    if (sttx && !full) m_q.push_back(wdata[7:0]);
    if (ldrx && m_held) m_held = 0;
    else if (uart_rx_valid && !m_held) begin m_held = 1; m_rxb = uart_rx_data; end
    m_cyc = clr ? 32'h0 : m_cyc + 32'd1;
    m_ins = clr ? 32'h0 : m_ins + {31'b0, instr_retire};
    @(posedge clk); #1;
    chk("tx_valid", {31'b0, uart_tx_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) chk("tx_data", {24'b0, uart_tx_data}, {24'b0, m_q[0]});
    chk("rx_ready", {31'b0, uart_rx_ready}, {31'b0, !m_held});
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d);
    addr = a; io_recv = 1;
    tick();
    io_recv = 0;
    d = rdata;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; io_trans = be;
    tick();
    io_trans = '0;
  endtask

  // Reset asserted away from the clock edge; outputs must clear without waiting for an edge.
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    chk("rst_rdata", rdata, 32'h0);
    model_reset();
    idle_in();
    tick(); tick();
    rst_n = 1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        ld;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] d;
  logic [7:0]  got[$];

  initial begin
    vecs[0]  = '{32'h80000000, 4'hF, 1'b0, 32'h0};  // store to RO status
    vecs[1]  = '{32'h80000000, 4'h0, 1'b1, 32'h1};
    vecs[2]  = '{32'h80000004, 4'hF, 1'b0, 32'h0};  // store to RO rx data
    vecs[3]  = '{32'h80000004, 4'h0, 1'b1, 32'h0};  // nothing held
    vecs[4]  = '{32'h80000008, 4'h0, 1'b1, 32'h0};  // WO tx data
    vecs[5]  = '{32'h80000018, 4'h0, 1'b1, 32'h0};  // WO clear
    vecs[6]  = '{32'h8000000C, 4'h0, 1'b1, 32'h0};  // unmapped
    vecs[7]  = '{32'h800000FC, 4'h0, 1'b1, 32'h0};
    vecs[8]  = '{32'h90000000, 4'h0, 1'b1, 32'h0};  // outside IO space
    vecs[9]  = '{32'h80000008, 4'hE, 1'b0, 32'h0};  // no byte-0 enable: no push
    vecs[10] = '{32'h90000008, 4'h1, 1'b0, 32'h0};  // outside IO space: no push
    vecs[11] = '{32'h80000000, 4'h0, 1'b1, 32'h1};

    model_reset();
    idle_in();
    #12;
    do_reset();

    // Counter read after 20 idle cycles: no pipeline offset, the load samples the count at its edge.
    for (int i = 0; i < 20; i++) tick();
    do_load(32'h80000010, d);
    chk("cycle_count_20", d, 32'd20);
    do_load(32'h80000000, d);
    chk("status_idle", d, 32'h1);

    uart_tx_ready = 1;
    foreach (vecs[i]) begin
      if (vecs[i].ld) begin
        do_load(vecs[i].addr, d);
        chk($sformatf("vec%0d", i), d, vecs[i].exp);
      end else begin
        do_store(vecs[i].addr, 32'hFFFFFF00 | i, vecs[i].be);
        chk($sformatf("vec%0d_no_tx", i), {31'b0, uart_tx_valid}, 32'h0);
      end
    end

    // FIFO fill and overflow
    uart_tx_ready = 0;
    for (int i = 0; i < 9; i++) do_store(32'h80000008, 32'h41 + i, 4'h1);
    do_load(32'h80000000, d);
    chk("status_full_ovf", d, 32'h4);
    do_load(32'h80000000, d);
    chk("status_ovf_cleared", d, 32'h0);
    uart_tx_ready = 1;
    got.delete();
    for (int i = 0; i < 12; i++) begin
      if (uart_tx_valid) got.push_back(uart_tx_data);
      tick();
    end
    chk("tx_drain_count", got.size(), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("tx_byte%0d", i), {24'b0, got[i]}, 32'h41 + i);

    // RX holding register
    uart_rx_data = 8'h5A; uart_rx_valid = 1;
    tick();
    uart_rx_valid = 0; uart_rx_data = 8'h33;
    chk("rx_ready_low", {31'b0, uart_rx_ready}, 32'h0);
    do_load(32'h80000000, d);
    chk("status_rx_held", d, 32'h3);
    do_load(32'h80000004, d);
    chk("rx_byte", d, 32'h5A);
    chk("rx_ready_back", {31'b0, uart_rx_ready}, 32'h1);

    // Counter clear during a retire
    instr_retire = 1;
    for (int i = 0; i < 5; i++) tick();
    do_store(32'h80000018, 32'h0, 4'hF);
    instr_retire = 0;
    do_load(32'h80000014, d);
    chk("instr_cleared", d, 32'h0);
    instr_retire = 1;
    for (int i = 0; i < 3; i++) tick();
    instr_retire = 0;
    do_load(32'h80000014, d);
    chk("instr_after_clear", d, 32'd3);

    // Reset with bytes queued and an rx byte held
    uart_tx_ready = 0;
    for (int i = 0; i < 3; i++) do_store(32'h80000008, 32'h61 + i, 4'h1);
    uart_rx_data = 8'h77; uart_rx_valid = 1;
    tick();
    uart_rx_valid = 0;
    chk("pre_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h1);
    do_reset();
    uart_tx_ready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_tx", {31'b0, uart_tx_valid}, 32'h0);
    end
    do_load(32'h80000000, d);
    chk("post_rst_status", d, 32'h1);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 2000; i++) begin
      int op;
      logic [7:0] offs[8];
      offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
      idle_in();
      uart_tx_ready = ($urandom_range(0, 3) == 0);
      uart_rx_valid = ($urandom_range(0, 3) == 0);
      uart_rx_data  = 8'($urandom);
      instr_retire  = $urandom_range(0, 1) == 1;
      wdata = $urandom;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: begin addr = 32'h80000008; io_trans = ($urandom_range(0, 4) == 0) ? 4'h2 : 4'h1; end
        3: begin addr = 32'h80000000; io_recv = 1; end
        4: begin addr = 32'h80000004; io_recv = 1; end
        5: begin addr = {4'h8, 20'($urandom), 8'h10 | 8'($urandom_range(0, 1) * 4)}; io_recv = 1; end
        6: begin if ($urandom_range(0, 15) == 0) begin addr = 32'h80000018; io_trans = 4'($urandom_range(1, 15)); end end
        7: begin addr = {$urandom_range(0, 1) ? 4'h8 : 4'h3, 20'($urandom), offs[$urandom_range(0, 7)]};
                 io_recv = $urandom_range(0, 1) == 1; io_trans = 4'($urandom); end
        default: ;
      endcase
      tick();
    end
    idle_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/io_mmio_ctrl.md
IO_MMIO_CTRL -- requirements
Module: io_mmio_ctrl

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8, TX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter IO_BASE, default 4'b1000, value of addr[31:28] selecting IO space.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 addr  input  32  load/store byte address from execute stage.
REQ-006 io_trans  input  4  store byte-enable into IO space, already hazard-qualified.
REQ-007 io_recv  input  1  load from IO space this cycle.
REQ-008 wdata  input  32  lane-aligned store data.
REQ-009 instr_retire  input  1  one instruction retired this cycle.
REQ-010 rdata  output  32  IO load data, registered.
REQ-011 uart_tx_data  output  8  byte to UART transmitter.
REQ-012 uart_tx_valid  output  1  uart_tx_data valid.
REQ-013 uart_tx_ready  input  1  transmitter accepts byte.
REQ-014 uart_rx_data  input  8  received byte.
REQ-015 uart_rx_valid  input  1  uart_rx_data valid.
REQ-016 uart_rx_ready  output  1  block can accept a received byte.

Function
REQ-017 Register map, decoded on addr[7:0] only when addr[31:28]==IO_BASE: 0x00 status (RO), 0x04 rx data (RO), 0x08 tx data (WO), 0x10 cycle count (RO), 0x14 instr count (RO), 0x18 counter clear (WO).
REQ-018 Status word: bit0 = TX FIFO not full, bit1 = rx byte held, bit2 = sticky tx_overflow, bits31:3 = 0.
REQ-019 Load latency exactly 1 cycle: rdata updates at edge following io_recv=1 and holds until next io_recv; unmapped offsets return 0.
REQ-020 Store to 0x08 with io_trans[0]=1 pushes wdata[7:0]; io_trans[0]=0 performs no push.
REQ-021 Push while FIFO full (judged on pre-edge state, even with simultaneous pop) is dropped and sets tx_overflow.
REQ-022 uart_tx_valid = FIFO non-empty; uart_tx_data = head entry; pop on uart_tx_valid & uart_tx_ready; simultaneous push and pop when not full both take effect, count unchanged.
REQ-023 FIFO pointers wrap modulo TX_DEPTH; occupancy counter width log2(TX_DEPTH)+1.
REQ-024 RX holding register single entry; uart_rx_ready = !rx_held (registered state, no combinational path from io_recv).
REQ-025 Byte captured when uart_rx_valid & uart_rx_ready; rx_held set.
REQ-026 Load of 0x04 returns {24'b0, rx byte} and clears rx_held; load of 0x04 with rx_held=0 returns 0, no state change.
REQ-027 Load of 0x00 returns status then clears tx_overflow; an overflow in same cycle keeps it set.
REQ-028 Cycle counter increments every cycle; instr counter increments when instr_retire=1; both 32-bit, wrap 0xFFFFFFFF->0.
REQ-029 Store to 0x18 with any io_trans bit set zeroes both counters; clear wins over increment that cycle.
REQ-030 Stores to RO offsets and loads of WO offsets have no side effects (WO loads return 0).

Reset
REQ-031 rst_n=0 SHALL immediately force: FIFO empty, uart_tx_valid=0, rx_held=0, uart_rx_ready=1 (after release), tx_overflow=0, both counters=0, rdata=0.
REQ-032 Reset mid-transfer discards FIFO contents and held rx byte; no partial byte is presented after release.

Structure
REQ-033 Register offsets, IO_BASE and status bit positions SHALL live in shared package/header io_mmio_defs alongside Opcode definitions.
REQ-034 TX FIFO SHALL be sub-module io_tx_fifo (parameterised depth, valid/ready pop); remaining logic in io_mmio_ctrl.

Verification
REQ-035 Reset, then 20 idle cycles, load 0x80000010 -> rdata=20 (+/- fixed pipeline offset documented in bench) one cycle later; status=0x1.
REQ-036 uart_tx_ready=0, store 0x41..0x49 (9 bytes) to 0x80000008 -> first 8 queued, status bit0=0, bit2=1; status read clears bit2; ready=1 -> bytes 0x41..0x48 out in order.
REQ-037 Drive rx byte 0x5A -> uart_rx_ready=0, status=0x3; load 0x80000004 -> rdata=0x5A, uart_rx_ready returns 1 next cycle.
REQ-038 instr_retire high 5 cycles, store to 0x80000018 during 6th retire -> instr count reads 0 then counts from 0.
REQ-039 Assert rst_n=0 with 3 bytes queued and rx held -> uart_tx_valid=0 immediately; after release, no bytes emitted, status=0x1.
